ras_manager: RTL and testbench
==============================

RAS_MANAGER -- requirements
Module: ras_manager

Interface
REQ-001 Parameters SHALL be: DEPTH, default 8, number of stack entries (power of 2); AW, default 32, return-address width.
REQ-002 Ports SHALL be: clk  in  1  clock; rst  in  1  asynchronous active-high reset; one clock, reset asynchronous and active-high.
REQ-003 Ports SHALL be: push  in  1  push push_addr; push_addr  in  AW  return address (PC+4 of jal/jalr with rd=ra).
REQ-004 Ports SHALL be: pop  in  1  pop top entry (predicted jalr target).
REQ-005 Ports SHALL be: rollback_pop_id  in  1  undo the push made by the ID-stage instruction; rollback_push_id  in  1  restore the entry popped by the ID-stage instruction; rollback_push_ex  in  1  restore the entry popped by the EX-stage instruction.
REQ-006 Ports SHALL be: PL_stall  in  1  pipeline stall, freezes pop history.
REQ-007 Ports SHALL be: WR_ra_track_en  in  1  write ra_track; WR_ra_track_data  in  5  new ra_track value.
REQ-008 Ports SHALL be: top_addr  out  AW  entry at top of stack; top_valid  out  1  count!=0; count  out  log2(DEPTH)+1  occupied entries; full  out  1  count==DEPTH; RAS_ra_track  out  5  register currently holding ra (5'd0 = ra saved on stack via sw).

Function
REQ-009 Storage SHALL be a circular array mem[DEPTH], top pointer tp (log2(DEPTH) bits, wraps modulo DEPTH), and saturating count.
REQ-010 top_addr SHALL be mem[tp] combinationally; top_valid, full SHALL derive combinationally from count.
REQ-011 Push only (no pop, no rollback): tp<=tp+1, mem[tp+1]<=push_addr, count<=min(count+1,DEPTH); when full, oldest entry is overwritten, count stays DEPTH.
REQ-012 Pop only: when count!=0, tp<=tp-1, count<=count-1, popped value mem[tp] captured into hist_id; when count==0, stack unchanged and hist_id<=0.
REQ-013 Push and pop same cycle: mem[tp]<=push_addr, tp and count unchanged, old mem[tp] captured into hist_id (0 if count==0, in which case count becomes 1).
REQ-014 Pop history SHALL be a 2-stage shift: hist_id (+ valid bit) and hist_ex (+ valid bit); when PL_stall=0 and no rollback, hist_ex<=hist_id and hist_id<=value popped this cycle (valid=pop && count!=0); when PL_stall=1, history holds.
REQ-015 Any rollback_* asserted SHALL take priority: push and pop ignored that cycle.
REQ-016 Rollbacks in one cycle SHALL apply in order: (1) rollback_pop_id: tp-=1, count-=1 (ignored if count==0); (2) rollback_push_id: if hist_id valid, push hist_id; (3) rollback_push_ex: if hist_ex valid, push hist_ex; final tp/count/mem SHALL equal sequential application, completed in one cycle.
REQ-017 Rollback restore pushes SHALL follow REQ-011 saturation rules.
REQ-018 After any rollback cycle, both history valid bits SHALL clear.
REQ-019 ra_track: when WR_ra_track_en=1, RAS_ra_track<=WR_ra_track_data, otherwise holds; unaffected by stall and rollback.
REQ-020 No combinational path SHALL exist from any input to count/full/top_valid; top_addr depends on state only.

Reset
REQ-021 On rst=1 (asynchronous, any cycle including mid-push/rollback): tp=0, count=0, history valid bits=0, hist values=0, RAS_ra_track=5'd1; mem contents need not reset; outputs top_valid=0, full=0, count=0.
REQ-022 First clk edge after rst deasserts SHALL process inputs normally.

Verification
REQ-023 Reset, push 0x100, 0x200, 0x300 -> count=3, top_addr=0x300; pop -> top_addr=0x200, count=2.
REQ-024 DEPTH=8: push 0x10..0x90 (9 pushes) -> count=8, full=1, top_addr=0x90; pop 8 times -> last top_addr=0x20, count=0, top_valid=0; further pop -> no change.
REQ-025 Stack [0xA,0xB] top 0xB: pop (ID) cycle 1, pop cycle 2 with push 0xC same cycle, then cycle 3 rollback_pop_id+rollback_push_id+rollback_push_ex -> top_addr=0xB, count=2, next entry 0xA.
REQ-026 Pop with PL_stall=1 held 3 cycles then rollback_push_ex -> no restore (hist_ex invalid), rollback_push_id restores popped value.
REQ-027 WR_ra_track_en=1, data=5'd5 -> RAS_ra_track=5; then data=5'd0 -> 0; rst asserted asynchronously mid-cycle -> RAS_ra_track=1, count=0 immediately.

Source files
------------

// File: rtl/ras_manager.sv
// Return-address stack: circular storage with saturating count and a two-stage
// pop history that lets ID/EX squashes undo pushes and restore popped entries.
module ras_manager #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic                     pop,
  input  logic                     rollback_pop_id,
  input  logic                     rollback_push_id,
  input  logic                     rollback_push_ex,
  input  logic                     PL_stall,
  input  logic                     WR_ra_track_en,
  input  logic [4:0]               WR_ra_track_data,
  output logic [AW-1:0]            top_addr,
  output logic                     top_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic [4:0]               RAS_ra_track
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [PW-1:0] TP_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] tp_q, tp_d, tp_a;
  logic [CW-1:0] count_q, count_d, cnt_a;
  logic [AW-1:0] hid_q, hid_d, hex_q, hex_d;
  logic          hid_v_q, hid_v_d, hex_v_q, hex_v_d;
  logic [4:0]    ra_q, ra_d;
  logic          we0, we1;
  logic [PW-1:0] wa0, wa1;
  logic [AW-1:0] wd0, wd1;
  logic          nonempty;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  always_comb begin
    tp_d     = tp_q;
    count_d  = count_q;
    hid_d    = hid_q;
    hid_v_d  = hid_v_q;
    hex_d    = hex_q;
    hex_v_d  = hex_v_q;
    ra_d     = WR_ra_track_en ? WR_ra_track_data : ra_q;
    we0      = 1'b0;
    wa0      = tp_q;
    wd0      = push_addr;
    we1      = 1'b0;
    wa1      = tp_q;
    wd1      = push_addr;
    tp_a     = tp_q;
    cnt_a    = count_q;
    nonempty = (count_q != '0);

    if (rollback_pop_id || rollback_push_id || rollback_push_ex) begin
      // Three rollbacks chained through tp_a/cnt_a so one cycle equals their
      // sequential application; the two restore writes land on distinct slots.
      if (rollback_pop_id && (cnt_a != '0)) begin
        tp_a  = tp_a - TP_ONE;
        cnt_a = cnt_a - CNT_ONE;
      end
      if (rollback_push_id && hid_v_q) begin
        tp_a  = tp_a + TP_ONE;
        cnt_a = sat_inc(cnt_a);
        we0   = 1'b1;
        wa0   = tp_a;
        wd0   = hid_q;
      end
      if (rollback_push_ex && hex_v_q) begin
        tp_a  = tp_a + TP_ONE;
        cnt_a = sat_inc(cnt_a);
        we1   = 1'b1;
        wa1   = tp_a;
        wd1   = hex_q;
      end
      tp_d    = tp_a;
      count_d = cnt_a;
      hid_v_d = 1'b0;
      hex_v_d = 1'b0;
    end else begin
      if (push && pop) begin
        we0 = 1'b1;
        wa0 = tp_q;
        if (!nonempty) count_d = CNT_ONE;
      end else if (push) begin
        tp_d    = tp_q + TP_ONE;
        we0     = 1'b1;
        wa0     = tp_q + TP_ONE;
        count_d = sat_inc(count_q);
      end else if (pop && nonempty) begin
        tp_d    = tp_q - TP_ONE;
        count_d = count_q - CNT_ONE;
      end
      if (!PL_stall) begin
        hex_d   = hid_q;
        hex_v_d = hid_v_q;
        hid_v_d = pop && nonempty;
        hid_d   = (pop && nonempty) ? mem_q[tp_q] : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tp_q    <= '0;
      count_q <= '0;
      hid_q   <= '0;
      hid_v_q <= 1'b0;
      hex_q   <= '0;
      hex_v_q <= 1'b0;
      ra_q    <= 5'd1;
    end else begin
      tp_q    <= tp_d;
      count_q <= count_d;
      hid_q   <= hid_d;
      hid_v_q <= hid_v_d;
      hex_q   <= hex_d;
      hex_v_q <= hex_v_d;
      ra_q    <= ra_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we0) mem_q[wa0] <= wd0;
    if (we1) mem_q[wa1] <= wd1;
  end

  assign top_addr     = mem_q[tp_q];
  assign top_valid    = (count_q != '0);
  assign full         = (count_q == CNT_MAX);
  assign count        = count_q;
  assign RAS_ra_track = ra_q;

endmodule

// File: tb/tb_ras_manager.sv
// Bench for ras_manager: directed scenarios plus random traffic compared against
// a queue-based model of the stack and its pop history.
module tb_ras_manager;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   push, pop, rollback_pop_id, rollback_push_id, rollback_push_ex;
  logic                   PL_stall, WR_ra_track_en;
  logic [AW-1:0]          push_addr;
  logic [4:0]             WR_ra_track_data;
  logic [AW-1:0]          top_addr;
  logic                   top_valid, full;
  logic [$clog2(DEPTH):0] count;
  logic [4:0]             RAS_ra_track;

  ras_manager #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .push(push), .push_addr(push_addr), .pop(pop),
    .rollback_pop_id(rollback_pop_id), .rollback_push_id(rollback_push_id),
    .rollback_push_ex(rollback_push_ex), .PL_stall(PL_stall),
    .WR_ra_track_en(WR_ra_track_en), .WR_ra_track_data(WR_ra_track_data),
    .top_addr(top_addr), .top_valid(top_valid), .count(count), .full(full),
    .RAS_ra_track(RAS_ra_track)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: stack as a queue (back = top), history as value/valid pairs.
  logic [AW-1:0] q[$];
  logic [AW-1:0] m_hid, m_hex;
  bit            m_hid_v, m_hex_v;
  logic [4:0]    m_ra;

  task automatic model_reset();
    q.delete();
    m_hid = '0; m_hex = '0; m_hid_v = 0; m_hex_v = 0; m_ra = 5'd1;
  endtask

  task automatic mpush(input logic [AW-1:0] v);
    if (q.size() == DEPTH) void'(q.pop_front());
    q.push_back(v);
  endtask

  task automatic model_step();
    bit            pv;
    logic [AW-1:0] pval;
    if (rollback_pop_id || rollback_push_id || rollback_push_ex) begin
      if (rollback_pop_id && q.size() > 0) void'(q.pop_back());
      if (rollback_push_id && m_hid_v) mpush(m_hid);
      if (rollback_push_ex && m_hex_v) mpush(m_hex);
      m_hid_v = 0;
      m_hex_v = 0;
    end else begin
      pv   = pop && (q.size() > 0);
      pval = pv ? q[q.size()-1] : '0;
      if (push && pop) begin
        if (q.size() > 0) q[q.size()-1] = push_addr;
        else q.push_back(push_addr);
      end else if (push) mpush(push_addr);
      else if (pv) void'(q.pop_back());
      if (!PL_stall) begin
        m_hex = m_hid; m_hex_v = m_hid_v;
        m_hid = pval;  m_hid_v = pv;
      end
    end
    if (WR_ra_track_en) m_ra = WR_ra_track_data;
  endtask

  task automatic compare_all(input string ph);
    check({ph, "_count"}, 64'(count), 64'(q.size()));
    check({ph, "_top_valid"}, 64'(top_valid), 64'(q.size() != 0));
    check({ph, "_full"}, 64'(full), 64'(q.size() == DEPTH));
    check({ph, "_ra_track"}, 64'(RAS_ra_track), 64'(m_ra));
    if (q.size() > 0) check({ph, "_top_addr"}, 64'(top_addr), 64'(q[q.size()-1]));
  endtask

  task automatic cycle(input string ph, input logic p, input logic [AW-1:0] pa, input logic po,
                       input logic rpi, input logic rpu, input logic rpe, input logic st,
                       input logic we, input logic [4:0] wd);
    push = p; push_addr = pa; pop = po;
    rollback_pop_id = rpi; rollback_push_id = rpu; rollback_push_ex = rpe;
    PL_stall = st; WR_ra_track_en = we; WR_ra_track_data = wd;
    @(posedge clk);
    model_step();
    #1;
    compare_all(ph);
  endtask

  task automatic push_c(input logic [AW-1:0] a);
    cycle("push", 1, a, 0, 0, 0, 0, 0, 0, 5'd0);
  endtask

  task automatic pop_c(input logic st);
    cycle("pop", 0, '0, 1, 0, 0, 0, st, 0, 5'd0);
  endtask

  // Starts just after a posedge; raises rst between edges and checks it acts at once.
  task automatic async_reset();
    #3 rst = 1'b1;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_ra", 64'(RAS_ra_track), 64'd1);
    check("arst_top_valid", 64'(top_valid), 64'd0);
    check("arst_full", 64'(full), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    compare_all("arst_rel");
  endtask

  initial begin
    rst = 1'b1;
    push = 0; push_addr = '0; pop = 0; rollback_pop_id = 0; rollback_push_id = 0;
    rollback_push_ex = 0; PL_stall = 0; WR_ra_track_en = 0; WR_ra_track_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_count", 64'(count), 64'd0);
    check("rst_top_valid", 64'(top_valid), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_ra", 64'(RAS_ra_track), 64'd1);

    // Basic push/pop
    push_c(32'h100); push_c(32'h200); push_c(32'h300);
    check("d23_count", 64'(count), 64'd3);
    check("d23_top", 64'(top_addr), 64'h300);
    pop_c(0);
    check("d23_pop_top", 64'(top_addr), 64'h200);
    check("d23_pop_count", 64'(count), 64'd2);

    // Overflow then drain
    async_reset();
    for (int i = 1; i <= 9; i++) push_c(32'(i * 16));
    check("d24_count", 64'(count), 64'd8);
    check("d24_full", 64'(full), 64'd1);
    check("d24_top", 64'(top_addr), 64'h90);
    for (int i = 0; i < 7; i++) pop_c(0);
    check("d24_last_top", 64'(top_addr), 64'h20);
    pop_c(0);
    check("d24_empty_count", 64'(count), 64'd0);
    check("d24_empty_valid", 64'(top_valid), 64'd0);
    pop_c(0);
    check("d24_extra_pop", 64'(count), 64'd0);

    // Full triple rollback
    async_reset();
    push_c(32'hA); push_c(32'hB);
    pop_c(0);
    cycle("d25_pushpop", 1, 32'hC, 1, 0, 0, 0, 0, 0, 5'd0);
    cycle("d25_rb", 0, '0, 0, 1, 1, 1, 0, 0, 5'd0);
    check("d25_top", 64'(top_addr), 64'hB);
    check("d25_count", 64'(count), 64'd2);
    pop_c(0);
    check("d25_next", 64'(top_addr), 64'hA);

    // Stall freezes history
    async_reset();
    push_c(32'h50); push_c(32'h60);
    pop_c(0);
    repeat (3) cycle("d26_stall", 0, '0, 0, 0, 0, 0, 1, 0, 5'd0);
    cycle("d26_rbex", 0, '0, 0, 0, 0, 1, 1, 0, 5'd0);
    check("d26_noex_count", 64'(count), 64'd1);
    push_c(32'h60);
    pop_c(0);
    repeat (3) cycle("d26_stall2", 0, '0, 0, 0, 0, 0, 1, 0, 5'd0);
    cycle("d26_rbid", 0, '0, 0, 0, 1, 1, 1, 0, 5'd0);
    check("d26_id_count", 64'(count), 64'd2);
    check("d26_id_top", 64'(top_addr), 64'h60);

    // ra_track and async reset
    cycle("d27_ra5", 0, '0, 0, 0, 0, 0, 0, 1, 5'd5);
    check("d27_ra5_val", 64'(RAS_ra_track), 64'd5);
    cycle("d27_ra0", 0, '0, 0, 0, 0, 0, 0, 1, 5'd0);
    check("d27_ra0_val", 64'(RAS_ra_track), 64'd0);
    cycle("d27_hold", 1, 32'h77, 0, 0, 0, 0, 0, 0, 5'd9);
    async_reset();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic rb;
      rb = ($urandom_range(0, 99) < 15);
      cycle("rnd",
            $urandom_range(0, 99) < 45, $urandom, $urandom_range(0, 99) < 40,
            rb && ($urandom_range(0, 1) == 1), rb && ($urandom_range(0, 1) == 1),
            rb && ($urandom_range(0, 1) == 1),
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10, 5'($urandom));
      if ($urandom_range(0, 399) == 0) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
